rom_access_arbiter: RTL and testbench



---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_access_arbiter_if.sv | 21 ++
 rtl/rom_access_arbiter_picker.sv | 34 +++
 rtl/rom_access_arbiter.sv | 122 ++++++++++++
 tb/tb_rom_access_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/rom_pkg.sv
// Shared types and constants for the ROM access arbiter.
//   ROM_ADDR_W / ROM_DATA_W : geometry of the 1K x 32 ROM macro
//   rom_arb_state_t         : arbiter FSM state encoding
package rom_pkg;
  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DATA_W = 32;
  localparam int LAT_CNT_W  = 2;   // holds ROM_LAT-1 for ROM_LAT up to 4

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } rom_arb_state_t;
endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester-side bus of the ROM access arbiter.
//   req_valid/req_addr/req_ready : request handshake (slice i of req_addr
//                                  belongs to requester i)
//   rsp_valid/rsp_data           : one-hot response pulse, shared data word
// master = requesters, slave = arbiter.
interface rom_access_arbiter_if
  import rom_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/rom_access_arbiter_picker.sv
// rr_picker: combinational round-robin priority picker.
//   req   : request vector
//   ptr   : index of the last granted requester
//   gnt   : one-hot grant (zero when no request)
//   idx   : binary index of the grant
//   any   : at least one request present
// Scan starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int unsigned c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int off = 1; off <= N; off++) begin
      c = (int'(ptr) + off) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end
endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one ROM macro among NUM_REQ requesters.
//   clk, rst  : core clock, synchronous active-high reset
//   bus       : requester handshake + response (rom_access_arbiter_if.slave)
//   busy      : FSM not in IDLE
//   cs_rom    : registered ROM chip select
//   adr_rom   : registered ROM address, held while idle
//   d_o_rom   : ROM read data, sampled ROM_LAT cycles after select
// One read in flight; throughput one read per ROM_LAT+2 cycles.
module rom_access_arbiter
  import rom_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_access_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 cs_rom,
  output logic [ADDR_W-1:0]    adr_rom,
  input  logic [DATA_W-1:0]    d_o_rom
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0]        PTR_RST = IW'(NUM_REQ - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LD  = LAT_CNT_W'(ROM_LAT - 1);

  rom_arb_state_t         state_q, state_d;
  logic                   cs_rom_q, cs_rom_d;
  logic [ADDR_W-1:0]      adr_rom_q, adr_rom_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          id_q, id_d;

  logic [NUM_REQ-1:0]     gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   gnt_any;
  logic [NUM_REQ-1:0]     req_ready;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    cs_rom_d    = cs_rom_q;
    adr_rom_d   = adr_rom_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    lat_cnt_d   = lat_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          id_d      = gnt_idx;
          rr_ptr_d  = gnt_idx;
          cs_rom_d  = 1'b1;
          adr_rom_d = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          lat_cnt_d = LAT_LD;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          // Response pulse is registered on the same edge that samples the
          // ROM, so it lines up with the RESP state cycle.
          rsp_data_d        = d_o_rom;
          rsp_valid_d[id_q] = 1'b1;
          cs_rom_d          = 1'b0;
          state_d           = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cs_rom_q    <= 1'b0;
      adr_rom_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      lat_cnt_q   <= '0;
      rr_ptr_q    <= PTR_RST;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      cs_rom_q    <= cs_rom_d;
      adr_rom_q   <= adr_rom_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      lat_cnt_q   <= lat_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != IDLE);
  assign cs_rom        = cs_rom_q;
  assign adr_rom       = adr_rom_q;

  a_ready_oh: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_oh:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid_q));
  a_cs_acc:   assert property (@(posedge clk) disable iff (rst) !(cs_rom_q && state_q != ACCESS));
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench: instance A (NUM_REQ=2, ROM_LAT=1) and instance B
// (NUM_REQ=4, ROM_LAT=3) share one clock. Inputs change 1ns after the
// rising edge, outputs are checked on the falling edge.
module tb_rom_access_arbiter;
  import rom_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        busy_a, busy_b, cs_a, cs_b;
  logic [9:0]  adr_a, adr_b;
  logic [31:0] dout_a, dout_b;
  int          cs_cnt_b;

  rom_access_arbiter_if #(.NUM_REQ(2)) ia ();
  rom_access_arbiter_if #(.NUM_REQ(4)) ib ();

  rom_access_arbiter #(.NUM_REQ(2), .ROM_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ia), .busy(busy_a),
    .cs_rom(cs_a), .adr_rom(adr_a), .d_o_rom(dout_a));

  rom_access_arbiter #(.NUM_REQ(4), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ib), .busy(busy_b),
    .cs_rom(cs_b), .adr_rom(adr_b), .d_o_rom(dout_b));

  function automatic logic [31:0] rom_f(input logic [9:0] a);
    if (a == 10'h155) return 32'hDEADBEEF;
    return {6'h2A, a, ~a, 6'h15};
  endfunction

  // ROM A: data valid whenever selected. ROM B: data valid only in the
  // third consecutive selected cycle, so early/late sampling shows up.
  always_comb dout_a = cs_a ? rom_f(adr_a) : 32'hBAD0BAD0;
  always @(posedge clk) cs_cnt_b <= cs_b ? cs_cnt_b + 1 : 0;
  always_comb dout_b = (cs_b && cs_cnt_b == 2) ? rom_f(adr_b) : 32'hBAD0BAD0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] ca [2];
    cs_cnt_b = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.req_valid = '0; ia.req_addr = '0;
    ib.req_valid = '0; ib.req_addr = '0;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    smp();
    chk("rst_cs",    {31'd0, cs_a},   32'd0);
    chk("rst_adr",   {22'd0, adr_a},  32'd0);
    chk("rst_rspv",  {30'd0, ia.rsp_valid}, 32'd0);
    chk("rst_rspd",  ia.rsp_data,     32'd0);
    chk("rst_busy",  {31'd0, busy_a}, 32'd0);

    // ---- A: single read of 0x155 ----
    tick();
    ia.req_valid = 2'b01; ia.req_addr[9:0] = 10'h155;
    smp(); chk("s_ready_c0", {30'd0, ia.req_ready}, 32'h1);
    tick(); ia.req_valid = '0;
    smp(); chk("s_cs_c1",  {31'd0, cs_a}, 32'd1);
           chk("s_adr_c1", {22'd0, adr_a}, 32'h155);
           chk("s_busy_c1", {31'd0, busy_a}, 32'd1);
    tick(); smp();
    chk("s_rspv_c2", {30'd0, ia.rsp_valid}, 32'h1);
    chk("s_rspd_c2", ia.rsp_data, 32'hDEADBEEF);
    chk("s_cs_c2",   {31'd0, cs_a}, 32'd0);
    tick(); smp();
    chk("s_busy_c3", {31'd0, busy_a}, 32'd0);
    chk("s_rspv_c3", {30'd0, ia.rsp_valid}, 32'd0);
    chk("s_hold_c3", ia.rsp_data, 32'hDEADBEEF);
    chk("s_adrhold", {22'd0, adr_a}, 32'h155);

    // ---- A: contention, both held from reset ----
    ca[0] = 10'h012; ca[1] = 10'h2A0;
    rst_a = 1'b1; ia.req_valid = 2'b11;
    ia.req_addr = {ca[1], ca[0]};
    tick(); rst_a = 1'b0;
    for (int g = 0; g < 4; g++) begin
      smp(); chk($sformatf("c_ready_%0d", g), {30'd0, ia.req_ready}, (g % 2) ? 32'h2 : 32'h1);
      tick(); smp();
      chk($sformatf("c_busy_ready_%0d", g), {30'd0, ia.req_ready}, 32'd0);
      chk($sformatf("c_adr_%0d", g), {22'd0, adr_a}, {22'd0, ca[g % 2]});
      tick(); smp();
      chk($sformatf("c_rspv_%0d", g), {30'd0, ia.rsp_valid}, (g % 2) ? 32'h2 : 32'h1);
      chk($sformatf("c_rspd_%0d", g), ia.rsp_data, rom_f(ca[g % 2]));
      tick();
    end
    ia.req_valid = '0;

    // ---- A: address extremes from requester 1 ----
    tick();
    ia.req_valid = 2'b10; ia.req_addr[19:10] = 10'h000;
    smp(); chk("x_ready0", {30'd0, ia.req_ready}, 32'h2);
    tick(); ia.req_addr[19:10] = 10'h3FF;
    smp(); chk("x_adr0", {22'd0, adr_a}, 32'h000);
    tick(); smp();
    chk("x_rspv0", {30'd0, ia.rsp_valid}, 32'h2);
    chk("x_rspd0", ia.rsp_data, rom_f(10'h000));
    tick(); smp(); chk("x_ready1", {30'd0, ia.req_ready}, 32'h2);
    tick(); ia.req_valid = '0;
    smp(); chk("x_adr1", {22'd0, adr_a}, 32'h3FF);
    tick(); smp();
    chk("x_rspv1", {30'd0, ia.rsp_valid}, 32'h2);
    chk("x_rspd1", ia.rsp_data, rom_f(10'h3FF));

    // ---- B: latency 3 with grant to requester 3 ----
    tick();
    ib.req_valid = 4'b1000; ib.req_addr[39:30] = 10'h2C3; ib.req_addr[9:0] = 10'h001;
    smp(); chk("l_ready_c0", {28'd0, ib.req_ready}, 32'h8);
    for (int c = 1; c <= 3; c++) begin
      tick(); ib.req_valid = '0;
      smp();
      chk($sformatf("l_cs_c%0d", c),  {31'd0, cs_b}, 32'd1);
      chk($sformatf("l_adr_c%0d", c), {22'd0, adr_b}, 32'h2C3);
      chk($sformatf("l_rspv_c%0d", c), {28'd0, ib.rsp_valid}, 32'd0);
    end
    tick(); ib.req_valid = 4'b1001;
    smp();
    chk("l_rspv_c4", {28'd0, ib.rsp_valid}, 32'h8);
    chk("l_rspd_c4", ib.rsp_data, rom_f(10'h2C3));
    chk("l_cs_c4",   {31'd0, cs_b}, 32'd0);

    // ---- B: wrap-around, ptr=3 so 0 wins, then 3 ----
    tick(); smp(); chk("w_ready_0", {28'd0, ib.req_ready}, 32'h1);
    tick(); tick(); tick(); tick(); smp();
    chk("w_rspv_0", {28'd0, ib.rsp_valid}, 32'h1);
    chk("w_rspd_0", ib.rsp_data, rom_f(10'h001));
    tick(); smp(); chk("w_ready_3", {28'd0, ib.req_ready}, 32'h8);
    tick(); ib.req_valid = '0;
    tick(); tick(); tick(); smp();
    chk("w_rspv_3", {28'd0, ib.rsp_valid}, 32'h8);

    // ---- B: reset mid-access ----
    tick();
    ib.req_valid = 4'b0010; ib.req_addr[19:10] = 10'h0AA;
    smp(); chk("r_ready_c0", {28'd0, ib.req_ready}, 32'h2);
    tick(); ib.req_valid = '0;
    tick(); rst_b = 1'b1;
    tick(); rst_b = 1'b0;
    smp();
    chk("r_cs",   {31'd0, cs_b}, 32'd0);
    chk("r_busy", {31'd0, busy_b}, 32'd0);
    chk("r_rspv", {28'd0, ib.rsp_valid}, 32'd0);
    tick(); smp(); chk("r_rspv_late", {28'd0, ib.rsp_valid}, 32'd0);
    tick(); ib.req_valid = 4'b0101; ib.req_addr[29:20] = 10'h111;
    smp(); chk("r_first_gnt", {28'd0, ib.req_ready}, 32'h1);
    tick(); ib.req_valid = '0;
    tick(); tick(); tick(); smp();
    chk("r_rspv_post", {28'd0, ib.rsp_valid}, 32'h1);
    chk("r_rspd_post", ib.rsp_data, rom_f(10'h001));

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
